pong_ball_engine: RTL and testbench
===================================

Name: pong_ball_engine

Overview:
- Game-logic stage directly downstream of the clock divider.
- Samples the divider's slow square wave (nominally 3 Hz) in the fast clock domain and turns each rising edge into a one-cycle game tick.
- On each tick, advances the ball on the 8x8 LED grid, resolves wall bounces and paddle hits or misses, and keeps score.
- Outputs feed the LED matrix renderer.

Parameters:
- WIN_SCORE, 4'd7: score that ends the game.
- POINT_HOLD, 2: ticks the ball stays in the miss column before the next serve (1..15).

Ports:
- CLK_IN  input  1: system clock; the only clock in the block.
- RST  input  1: synchronous, active-high reset.
- SLOW_CLK  input  1: divider output; treated as a data signal and never used as a clock.
- START  input  1: start/restart request, level; sampled on tick only.
- PAD_L  input  3: left paddle top row (paddle = rows PAD_L..PAD_L+2, column 0); values 6,7 clamp to 5.
- PAD_R  input  3: right paddle top row (column 7); same clamping as PAD_L.
- BALL_X  output  3: ball column, 0..7.
- BALL_Y  output  3: ball row, 0..7.
- SCORE_L  output  4: left player score.
- SCORE_R  output  4: right player score.
- GAME_STATE  output  3: 0 IDLE, 1 PLAY, 2 POINT, 3 OVER.
- POINT_L  output  1: one-CLK_IN pulse when the left player scores.
- POINT_R  output  1: one-CLK_IN pulse when the right player scores.
- WINNER  output  1: 0 = left, 1 = right; valid in OVER.

Behaviour:
- Reset is synchronous and active-high: while RST=1 at a CLK_IN edge, all state clears. Values after reset:
  - state IDLE; BALL_X=3, BALL_Y=3; dx=+1, dy=+1.
  - SCORE_L=0, SCORE_R=0; POINT_L=0, POINT_R=0; WINNER=0.
  - Synchronizer and edge registers cleared.
  - Reset mid-game abandons the game immediately.
- Tick generation:
  - SLOW_CLK passes through a 2-flop synchronizer, then an edge register.
  - tick=1 for exactly one cycle when sync2=1 and prev=0.
  - A SLOW_CLK rise at edge N produces tick high during the cycle after edge N+2.
  - No tick is generated for falling edges.
  - All state changes below happen only on CLK_IN edges where tick=1, except the RST clear and the pulse deassertion.
- IDLE:
  - Ball held at (3,3).
  - On tick with START=1: enter PLAY with dx=+1, dy=+1; ball unchanged.
- PLAY (per tick):
  - Vertical:
    - if BALL_Y=7 and dy=+1, or BALL_Y=0 and dy=-1, negate dy first;
    - then ny = BALL_Y + dy.
  - Horizontal, using ny for the paddle check:
    - Moving left, BALL_X=1:
      - if PAD_L(clamped) <= ny <= PAD_L+2: dx=+1, nx=2 (hit);
      - else nx=0, SCORE_R+1, POINT_R pulse, enter POINT (miss).
    - Moving right, BALL_X=6: mirror case with PAD_R; miss sets nx=7, SCORE_L+1, POINT_L pulse.
    - Otherwise nx = BALL_X + dx.
  - Paddle input changes between ticks have no effect; only the value present on the tick cycle counts.
  - START is ignored in PLAY.
- POINT:
  - Ball frozen in the miss column; count POINT_HOLD ticks.
  - On the final tick, if the scorer's score = WIN_SCORE: enter OVER with WINNER = scorer.
  - Otherwise serve and return to PLAY:
    - ball y=3, dy=+1;
    - serve goes toward the player who conceded: conceded left → x=4, dx=-1; conceded right → x=3, dx=+1.
- OVER:
  - Ball and scores frozen.
  - On tick with START=1: clear scores, ball (3,3), dx=+1, dy=+1, enter PLAY.
- Scores saturate at 15 (unreachable with legal WIN_SCORE).
- POINT_L and POINT_R are never both high. They drop the cycle after assertion.
- Outputs are registered. Position updates are visible the cycle after the tick.

Test Plan:
- Reset and tick timing: RST high for 2 cycles, then toggle SLOW_CLK every 8 cycles → outputs hold reset values (state 0, ball (3,3), scores 0); exactly one tick per SLOW_CLK rise, occurring 3 cycles after the rise; none on falls.
- Start and wall bounce:
  - START=1 on the first tick → PLAY; subsequent ticks give ball (4,4),(5,5),(6,6).
  - Ball at y=7 with dy=+1 → next tick y=6, dy=-1.
- Paddle hit: ball (6,6) moving right with dy=+1, PAD_R=5 → next tick ny=7 is within 5..7; ball (5,7), dx=-1; no point pulse.
- Miss and serve, POINT_HOLD=2:
  - PAD_R=0 with ball reaching x=6 at ny=6 → ball (7,6), SCORE_L=1, one-cycle POINT_L, state 2.
  - After 2 more ticks → ball (3,3) moving right, state 1.
- Game over: preload scores to WIN_SCORE-1 (force left to miss) → on the final POINT tick, state 3, WINNER=1.
  - Further ticks without START → nothing changes.
  - START → scores 0, PLAY.
- Clamp and reset mid-play: PAD_L=7 acts as 5 (hit at ny=5..7, miss at ny=4); RST pulsed mid-PLAY → reset values on the next cycle.

Source files
------------

// File: rtl/pong_ball_engine.sv
// Pong game logic for an 8x8 LED grid. Each rising edge of the slow divider wave becomes
// a one-cycle tick that moves the ball, resolves bounces and paddle hits, and keeps score.
module pong_ball_engine #(
    parameter logic [3:0] WIN_SCORE  = 4'd7,
    parameter int         POINT_HOLD = 2
) (
    input  logic       CLK_IN,
    input  logic       RST,
    input  logic       SLOW_CLK,
    input  logic       START,
    input  logic [2:0] PAD_L,
    input  logic [2:0] PAD_R,
    output logic [2:0] BALL_X,
    output logic [2:0] BALL_Y,
    output logic [3:0] SCORE_L,
    output logic [3:0] SCORE_R,
    output logic [2:0] GAME_STATE,
    output logic       POINT_L,
    output logic       POINT_R,
    output logic       WINNER
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_POINT = 3'd2,
        ST_OVER  = 3'd3
    } state_e;

    localparam logic [3:0] HOLD_LAST = 4'(POINT_HOLD - 1);
    localparam logic [2:0] PAD_MAX   = 3'd5;
    localparam logic [2:0] CENTER    = 3'd3;

    function automatic logic [2:0] clamp_pad(input logic [2:0] pad);
        return (pad > PAD_MAX) ? PAD_MAX : pad;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'd15) ? s : s + 4'd1;
    endfunction

    function automatic logic covers(input logic [2:0] pad, input logic [2:0] row);
        return (row >= pad) && ({1'b0, row} <= ({1'b0, pad} + 4'd2));
    endfunction

    // SLOW_CLK is sampled as data: two synchronizer stages plus an edge register.
    logic       sync1_q, sync2_q, prev_q;
    logic       tick;

    state_e     state_q, state_d;
    logic [2:0] x_q, x_d;
    logic [2:0] y_q, y_d;
    logic       dx_neg_q, dx_neg_d;
    logic       dy_neg_q, dy_neg_d;
    logic [3:0] score_l_q, score_l_d;
    logic [3:0] score_r_q, score_r_d;
    logic       point_l_q, point_l_d;
    logic       point_r_q, point_r_d;
    logic       winner_q, winner_d;
    logic       scorer_q, scorer_d;
    logic [3:0] hold_q, hold_d;

    logic       dy_flip;
    logic       dy_eff;
    logic [2:0] ny;
    logic [2:0] pad_l_c;
    logic [2:0] pad_r_c;

    assign tick = sync2_q & ~prev_q;

    // The vertical bounce is resolved before stepping so ny is where the ball lands.
    assign dy_flip = ((y_q == 3'd7) && !dy_neg_q) || ((y_q == 3'd0) && dy_neg_q);
    assign dy_eff  = dy_neg_q ^ dy_flip;
    assign ny      = dy_eff ? (y_q - 3'd1) : (y_q + 3'd1);
    assign pad_l_c = clamp_pad(PAD_L);
    assign pad_r_c = clamp_pad(PAD_R);

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no branch can infer a latch.
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dx_neg_d  = dx_neg_q;
        dy_neg_d  = dy_neg_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        point_l_d = 1'b0;
        point_r_d = 1'b0;
        winner_d  = winner_q;
        scorer_d  = scorer_q;
        hold_d    = hold_q;

        unique case (state_q)
            ST_IDLE: begin
                x_d = CENTER;
                y_d = CENTER;
                if (tick && START) begin
                    state_d  = ST_PLAY;
                    dx_neg_d = 1'b0;
                    dy_neg_d = 1'b0;
                end
            end

            ST_PLAY: begin
                if (tick) begin
                    dy_neg_d = dy_eff;
                    y_d      = ny;
                    if (dx_neg_q && (x_q == 3'd1)) begin
                        if (covers(pad_l_c, ny)) begin
                            dx_neg_d = 1'b0;
                            x_d      = 3'd2;
                        end else begin
                            x_d       = 3'd0;
                            score_r_d = sat_inc(score_r_q);
                            point_r_d = 1'b1;
                            scorer_d  = 1'b1;
                            hold_d    = 4'd0;
                            state_d   = ST_POINT;
                        end
                    end else if (!dx_neg_q && (x_q == 3'd6)) begin
                        if (covers(pad_r_c, ny)) begin
                            dx_neg_d = 1'b1;
                            x_d      = 3'd5;
                        end else begin
                            x_d       = 3'd7;
                            score_l_d = sat_inc(score_l_q);
                            point_l_d = 1'b1;
                            scorer_d  = 1'b0;
                            hold_d    = 4'd0;
                            state_d   = ST_POINT;
                        end
                    end else begin
                        x_d = dx_neg_q ? (x_q - 3'd1) : (x_q + 3'd1);
                    end
                end
            end

            ST_POINT: begin
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        if ((scorer_q ? score_r_q : score_l_q) == WIN_SCORE) begin
                            state_d  = ST_OVER;
                            winner_d = scorer_q;
                        end else begin
                            // Serve toward the player who just conceded.
                            state_d  = ST_PLAY;
                            y_d      = CENTER;
                            dy_neg_d = 1'b0;
                            x_d      = scorer_q ? 3'd4 : CENTER;
                            dx_neg_d = scorer_q;
                        end
                    end else begin
                        hold_d = hold_q + 4'd1;
                    end
                end
            end

            ST_OVER: begin
                if (tick && START) begin
                    state_d   = ST_PLAY;
                    score_l_d = 4'd0;
                    score_r_d = 4'd0;
                    x_d       = CENTER;
                    y_d       = CENTER;
                    dx_neg_d  = 1'b0;
                    dy_neg_d  = 1'b0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (RST) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            state_q   <= ST_IDLE;
            x_q       <= CENTER;
            y_q       <= CENTER;
            dx_neg_q  <= 1'b0;
            dy_neg_q  <= 1'b0;
            score_l_q <= 4'd0;
            score_r_q <= 4'd0;
            point_l_q <= 1'b0;
            point_r_q <= 1'b0;
            winner_q  <= 1'b0;
            scorer_q  <= 1'b0;
            hold_q    <= 4'd0;
        end else begin
            sync1_q   <= SLOW_CLK;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dx_neg_q  <= dx_neg_d;
            dy_neg_q  <= dy_neg_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            point_l_q <= point_l_d;
            point_r_q <= point_r_d;
            winner_q  <= winner_d;
            scorer_q  <= scorer_d;
            hold_q    <= hold_d;
        end
    end

    assign BALL_X     = x_q;
    assign BALL_Y     = y_q;
    assign SCORE_L    = score_l_q;
    assign SCORE_R    = score_r_q;
    assign GAME_STATE = state_q;
    assign POINT_L    = point_l_q;
    assign POINT_R    = point_r_q;
    assign WINNER     = winner_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: each game tick pushes its expected ball/score/state
// onto a scoreboard, which is popped and checked once the tick has been applied.
module tb_pong_ball_engine;

    localparam logic [3:0] WIN        = 4'd7;
    localparam int         HOLD_TICKS = 2;

    logic       CLK_IN = 1'b0;
    logic       RST;
    logic       SLOW_CLK;
    logic       START;
    logic [2:0] PAD_L;
    logic [2:0] PAD_R;
    logic [2:0] BALL_X;
    logic [2:0] BALL_Y;
    logic [3:0] SCORE_L;
    logic [3:0] SCORE_R;
    logic [2:0] GAME_STATE;
    logic       POINT_L;
    logic       POINT_R;
    logic       WINNER;

    pong_ball_engine #(
        .WIN_SCORE (WIN),
        .POINT_HOLD(HOLD_TICKS)
    ) dut (
        .CLK_IN    (CLK_IN),
        .RST       (RST),
        .SLOW_CLK  (SLOW_CLK),
        .START     (START),
        .PAD_L     (PAD_L),
        .PAD_R     (PAD_R),
        .BALL_X    (BALL_X),
        .BALL_Y    (BALL_Y),
        .SCORE_L   (SCORE_L),
        .SCORE_R   (SCORE_R),
        .GAME_STATE(GAME_STATE),
        .POINT_L   (POINT_L),
        .POINT_R   (POINT_R),
        .WINNER    (WINNER)
    );

    always #5 CLK_IN = ~CLK_IN;

    typedef struct {
        string       tag;
        logic [16:0] vec;
        logic [1:0]  pulse;
    } exp_t;

    exp_t sb[$];

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic pl_at, pr_at, pl_after, pr_after;
    int   points, last_pt, over_t;

    // Packed {x, y, score_l, score_r, state}.
    function automatic logic [16:0] pk(input logic [2:0] x, input logic [2:0] y,
                                       input logic [3:0] sl, input logic [3:0] sr,
                                       input logic [2:0] st);
        return {x, y, sl, sr, st};
    endfunction

    function automatic logic [16:0] obs_vec();
        return {BALL_X, BALL_Y, SCORE_L, SCORE_R, GAME_STATE};
    endfunction

    // Right paddle placed so the ball always lands on it.
    function automatic logic [2:0] hit_pad(input logic [2:0] y);
        if (y == 3'd0) return 3'd0;
        if (y == 3'd7) return 3'd5;
        return y - 3'd1;
    endfunction

    // Left paddle placed so the ball always misses it.
    function automatic logic [2:0] miss_pad(input logic [2:0] y);
        return (y >= 3'd4) ? 3'd0 : 3'd5;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    // One SLOW_CLK period; the tick lands on the third edge after the rise.
    task automatic run_tick();
        @(posedge CLK_IN);
        #1 SLOW_CLK = 1'b1;
        repeat (3) @(posedge CLK_IN);
        #1;
        pl_at = POINT_L;
        pr_at = POINT_R;
        @(posedge CLK_IN);
        #1;
        pl_after = POINT_L;
        pr_after = POINT_R;
        SLOW_CLK = 1'b0;
        repeat (4) @(posedge CLK_IN);
        #1;
    endtask

    task automatic step(input string tag, input logic [16:0] vec, input logic [1:0] pulse);
        exp_t e;
        e.tag   = tag;
        e.vec   = vec;
        e.pulse = pulse;
        sb.push_back(e);
        run_tick();
        e = sb.pop_front();
        cmp({e.tag, ".pulse"}, {30'd0, pl_at, pr_at}, {30'd0, e.pulse});
        cmp({e.tag, ".pulse_drop"}, {30'd0, pl_after, pr_after}, 32'd0);
        cmp(e.tag, {15'd0, obs_vec()}, {15'd0, e.vec});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b1;
        SLOW_CLK = 1'b0;
        START    = 1'b0;
        PAD_L    = 3'd0;
        PAD_R    = 3'd0;
        repeat (2) @(posedge CLK_IN);
        #1 RST = 1'b0;

        cmp("reset_vec", {15'd0, obs_vec()}, {15'd0, pk(3, 3, 0, 0, 0)});
        cmp("reset_flags", {29'd0, POINT_L, POINT_R, WINNER}, 32'd0);

        step("idle_no_start", pk(3, 3, 0, 0, 0), 2'b00);

        // Tick latency: state must change exactly on the third edge after the rise.
        START = 1'b1;
        @(posedge CLK_IN);
        #1 SLOW_CLK = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(posedge CLK_IN);
            #1;
            cmp($sformatf("tick_latency_%0d", k), {29'd0, GAME_STATE}, (k < 3) ? 32'd0 : 32'd1);
        end
        @(posedge CLK_IN);
        #1 SLOW_CLK = 1'b0;
        repeat (5) @(posedge CLK_IN);
        #1;
        START = 1'b0;
        cmp("start_play_no_fall_tick", {15'd0, obs_vec()}, {15'd0, pk(3, 3, 0, 0, 1)});

        step("move_1", pk(4, 4, 0, 0, 1), 2'b00);
        step("move_2", pk(5, 5, 0, 0, 1), 2'b00);
        step("move_3", pk(6, 6, 0, 0, 1), 2'b00);
        PAD_R = 3'd5;
        step("pad_r_hit", pk(5, 7, 0, 0, 1), 2'b00);
        step("wall_top", pk(4, 6, 0, 0, 1), 2'b00);
        step("move_4", pk(3, 5, 0, 0, 1), 2'b00);
        step("move_5", pk(2, 4, 0, 0, 1), 2'b00);
        step("move_6", pk(1, 3, 0, 0, 1), 2'b00);
        PAD_L = 3'd0;
        step("pad_l_hit", pk(2, 2, 0, 0, 1), 2'b00);
        step("move_7", pk(3, 1, 0, 0, 1), 2'b00);
        step("move_8", pk(4, 0, 0, 0, 1), 2'b00);
        step("wall_bottom", pk(5, 1, 0, 0, 1), 2'b00);
        step("move_9", pk(6, 2, 0, 0, 1), 2'b00);
        PAD_R = 3'd0;
        step("miss_right", pk(7, 3, 1, 0, 2), 2'b10);
        step("point_hold", pk(7, 3, 1, 0, 2), 2'b00);
        step("serve_right", pk(3, 3, 1, 0, 1), 2'b00);

        step("rally_1", pk(4, 4, 1, 0, 1), 2'b00);
        step("rally_2", pk(5, 5, 1, 0, 1), 2'b00);
        step("rally_3", pk(6, 6, 1, 0, 1), 2'b00);
        PAD_R = 3'd6;
        step("pad_r6_hit", pk(5, 7, 1, 0, 1), 2'b00);
        step("rally_4", pk(4, 6, 1, 0, 1), 2'b00);
        step("rally_5", pk(3, 5, 1, 0, 1), 2'b00);
        step("rally_6", pk(2, 4, 1, 0, 1), 2'b00);
        step("rally_7", pk(1, 3, 1, 0, 1), 2'b00);
        PAD_L = 3'd1;
        step("pad_l1_hit", pk(2, 2, 1, 0, 1), 2'b00);
        step("rally_8", pk(3, 1, 1, 0, 1), 2'b00);
        step("rally_9", pk(4, 0, 1, 0, 1), 2'b00);
        step("rally_10", pk(5, 1, 1, 0, 1), 2'b00);
        step("rally_11", pk(6, 2, 1, 0, 1), 2'b00);
        PAD_R = 3'd2;
        step("pad_r2_hit", pk(5, 3, 1, 0, 1), 2'b00);
        step("rally_12", pk(4, 4, 1, 0, 1), 2'b00);
        step("rally_13", pk(3, 5, 1, 0, 1), 2'b00);
        step("rally_14", pk(2, 6, 1, 0, 1), 2'b00);
        step("rally_15", pk(1, 7, 1, 0, 1), 2'b00);
        PAD_L = 3'd7;
        step("pad_l7_clamp_hit", pk(2, 6, 1, 0, 1), 2'b00);
        step("rally_16", pk(3, 5, 1, 0, 1), 2'b00);
        step("rally_17", pk(4, 4, 1, 0, 1), 2'b00);
        step("rally_18", pk(5, 3, 1, 0, 1), 2'b00);
        step("rally_19", pk(6, 2, 1, 0, 1), 2'b00);
        PAD_R = 3'd7;
        step("pad_r7_clamp_miss", pk(7, 1, 2, 0, 2), 2'b10);
        step("point_hold_2", pk(7, 1, 2, 0, 2), 2'b00);
        step("serve_right_2", pk(3, 3, 2, 0, 1), 2'b00);
        step("rally_20", pk(4, 4, 2, 0, 1), 2'b00);

        // Reset in the middle of a rally abandons the game on the next edge.
        @(posedge CLK_IN);
        #1 RST = 1'b1;
        @(posedge CLK_IN);
        #1;
        cmp("mid_reset_vec", {15'd0, obs_vec()}, {15'd0, pk(3, 3, 0, 0, 0)});
        cmp("mid_reset_flags", {29'd0, POINT_L, POINT_R, WINNER}, 32'd0);
        RST = 1'b0;

        START = 1'b1;
        step("restart_after_reset", pk(3, 3, 0, 0, 1), 2'b00);
        START = 1'b0;

        // Left always misses, right always returns, until the game ends.
        points  = 0;
        last_pt = -1;
        over_t  = -1;
        for (int t = 0; t < 200 && over_t < 0; t++) begin
            PAD_R = hit_pad(BALL_Y);
            PAD_L = miss_pad(BALL_Y);
            run_tick();
            if (pr_at) begin
                points++;
                cmp($sformatf("race_score_r_%0d", points), {28'd0, SCORE_R}, 32'(points));
                if (points == int'(WIN)) last_pt = t;
            end
            if (GAME_STATE == 3'd3) over_t = t;
        end
        cmp("game_over_reached", {29'd0, GAME_STATE}, 32'd3);
        cmp("over_after_hold", 32'(over_t - last_pt), 32'(HOLD_TICKS));
        cmp("over_state", {16'd0, BALL_X, SCORE_L, SCORE_R, GAME_STATE, WINNER, 1'b0},
            {16'd0, 3'd0, 4'd0, WIN, 3'd3, 1'b1, 1'b0});

        run_tick();
        run_tick();
        cmp("over_frozen", {16'd0, BALL_X, SCORE_L, SCORE_R, GAME_STATE, WINNER, 1'b0},
            {16'd0, 3'd0, 4'd0, WIN, 3'd3, 1'b1, 1'b0});

        START = 1'b1;
        step("restart_from_over", pk(3, 3, 0, 0, 1), 2'b00);
        START = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
